// File: rtl/execute_stage.sv
// EX pipeline stage: ALU-control decode, ALU/shift/multiply, branch-target add,
// destination select, the HI/LO registers and the EX/MEM pipeline register.
module execute_stage #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [1:0]      ALUOpIn,
    input  logic            RegDstIn,
    input  logic            ALUSrcIn,
    input  logic            BranchIn,
    input  logic            MemReadIn,
    input  logic            MemWriteIn,
    input  logic            MemToRegIn,
    input  logic            RegWriteIn,
    input  logic [31:0]     regAIn,
    input  logic [31:0]     regBIn,
    input  logic [31:0]     signExtendIn,
    input  logic [PC_W-1:0] PcCountIn,
    input  logic [4:0]      rtIn,
    input  logic [4:0]      rdIn,
    output logic            BranchOut,
    output logic            MemReadOut,
    output logic            MemWriteOut,
    output logic            MemToRegOut,
    output logic            RegWriteOut,
    output logic [31:0]     aluResult,
    output logic            zero,
    output logic [31:0]     storeData,
    output logic [4:0]      writeRegister,
    output logic [PC_W-1:0] branchTarget
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_opb;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu;
    logic        w_wr_ok;
    logic        w_mul;
    logic        w_mul_s;
    logic [63:0] w_prod;

    assign w_opb   = ALUSrcIn ? signExtendIn : regBIn;
    assign w_funct = signExtendIn[5:0];
    assign w_shamt = signExtendIn[10:6];

    // Both operands widened to 64 bits so the low 64 bits of the product are exact.
    assign w_prod = w_mul_s
        ? ({{32{regAIn[31]}}, regAIn} * {{32{regBIn[31]}}, regBIn})
        : ({32'b0, regAIn} * {32'b0, regBIn});

    always_comb begin
        w_alu   = '0;
        w_wr_ok = 1'b1;
        w_mul   = 1'b0;
        w_mul_s = 1'b0;
        case (ALUOpIn)
            2'b00: w_alu = regAIn + w_opb;
            2'b01: w_alu = regAIn - w_opb;
            2'b11: w_alu = regAIn | w_opb;
            default: begin
                case (w_funct)
                    6'h20, 6'h21: w_alu = regAIn + w_opb;
                    6'h22, 6'h23: w_alu = regAIn - w_opb;
                    6'h24: w_alu = regAIn & w_opb;
                    6'h25: w_alu = regAIn | w_opb;
                    6'h26: w_alu = regAIn ^ w_opb;
                    6'h27: w_alu = ~(regAIn | w_opb);
                    6'h2A: w_alu = {31'b0, $signed(regAIn) < $signed(w_opb)};
                    6'h2B: w_alu = {31'b0, regAIn < w_opb};
                    6'h00: w_alu = regBIn << w_shamt;
                    6'h02: w_alu = regBIn >> w_shamt;
                    6'h03: w_alu = $unsigned($signed(regBIn) >>> w_shamt);
                    6'h10: w_alu = r_hi;
                    6'h12: w_alu = r_lo;
                    6'h18: begin
                        w_mul   = 1'b1;
                        w_mul_s = 1'b1;
                        w_wr_ok = 1'b0;
                    end
                    6'h19: begin
                        w_mul   = 1'b1;
                        w_wr_ok = 1'b0;
                    end
                    default: w_wr_ok = 1'b0;
                endcase
            end
        endcase
    end

    // A flushed slot is a full bubble: controls and data all zero, HI/LO kept.
    always_ff @(negedge clk) begin
        if (reset || flush) begin
            BranchOut     <= 1'b0;
            MemReadOut    <= 1'b0;
            MemWriteOut   <= 1'b0;
            MemToRegOut   <= 1'b0;
            RegWriteOut   <= 1'b0;
            aluResult     <= '0;
            zero          <= 1'b0;
            storeData     <= '0;
            writeRegister <= '0;
            branchTarget  <= '0;
            if (reset) begin
                r_hi <= '0;
                r_lo <= '0;
            end
        end else if (!stall) begin
            BranchOut     <= BranchIn;
            MemReadOut    <= MemReadIn;
            MemWriteOut   <= MemWriteIn;
            MemToRegOut   <= MemToRegIn;
            RegWriteOut   <= RegWriteIn & w_wr_ok;
            aluResult     <= w_alu;
            zero          <= (w_alu == 32'b0);
            storeData     <= regBIn;
            writeRegister <= RegDstIn ? rdIn : rtIn;
            branchTarget  <= PcCountIn + signExtendIn[PC_W-1:0];
            if (w_mul) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized
// instructions compared against a behavioural model of the stage.
module tb_execute_stage;

    localparam int PC_W = 10;

    logic            clk;
    logic            reset, stall, flush;
    logic [1:0]      ALUOpIn;
    logic            RegDstIn, ALUSrcIn;
    logic            BranchIn, MemReadIn, MemWriteIn, MemToRegIn, RegWriteIn;
    logic [31:0]     regAIn, regBIn, signExtendIn;
    logic [PC_W-1:0] PcCountIn;
    logic [4:0]      rtIn, rdIn;
    logic            BranchOut, MemReadOut, MemWriteOut, MemToRegOut, RegWriteOut;
    logic [31:0]     aluResult;
    logic            zero;
    logic [31:0]     storeData;
    logic [4:0]      writeRegister;
    logic [PC_W-1:0] branchTarget;

    typedef struct packed {
        logic            br, mr, mw, mt, rw;
        logic [31:0]     alu;
        logic            z;
        logic [31:0]     sd;
        logic [4:0]      wr;
        logic [PC_W-1:0] bt;
    } out_t;

    out_t        exp_o;
    out_t        got_o;
    logic [31:0] m_hi, m_lo;
    int          n_chk = 0;
    int          n_fail = 0;

    execute_stage #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ALUOpIn(ALUOpIn), .RegDstIn(RegDstIn), .ALUSrcIn(ALUSrcIn),
        .BranchIn(BranchIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemToRegIn(MemToRegIn), .RegWriteIn(RegWriteIn),
        .regAIn(regAIn), .regBIn(regBIn), .signExtendIn(signExtendIn),
        .PcCountIn(PcCountIn), .rtIn(rtIn), .rdIn(rdIn),
        .BranchOut(BranchOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .MemToRegOut(MemToRegOut), .RegWriteOut(RegWriteOut),
        .aluResult(aluResult), .zero(zero), .storeData(storeData),
        .writeRegister(writeRegister), .branchTarget(branchTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got_o = '{BranchOut, MemReadOut, MemWriteOut, MemToRegOut, RegWriteOut,
                     aluResult, zero, storeData, writeRegister, branchTarget};

    // Model one falling edge from the current inputs, then let the edge happen.
    task automatic tick();
        out_t        n;
        logic [31:0] a, b, r;
        logic [5:0]  f;
        int          sh;
        bit          ok, mul;
        longint unsigned p;
        n = exp_o;
        a = regAIn;
        b = ALUSrcIn ? signExtendIn : regBIn;
        f = signExtendIn[5:0];
        sh = int'(signExtendIn[10:6]);
        r = 0; ok = 1; mul = 0; p = 0;
        if (reset) begin
            n = '0; m_hi = 0; m_lo = 0;
        end else if (flush) begin
            n = '0;
        end else if (!stall) begin
            case (ALUOpIn)
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd3: r = a | b;
                default: case (f)
                    6'h20, 6'h21: r = a + b;
                    6'h22, 6'h23: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h26: r = a ^ b;
                    6'h27: r = ~(a | b);
                    6'h2A: r = (int'(a) < int'(b)) ? 1 : 0;
                    6'h2B: r = (a < b) ? 1 : 0;
                    6'h00: r = regBIn << sh;
                    6'h02: r = regBIn >> sh;
                    6'h03: r = int'(regBIn) >>> sh;
                    6'h10: r = m_hi;
                    6'h12: r = m_lo;
                    6'h18: begin
                        p = longint'(int'(a)) * longint'(int'(regBIn));
                        mul = 1; ok = 0;
                    end
                    6'h19: begin
                        p = longint'(a) * longint'(regBIn);
                        mul = 1; ok = 0;
                    end
                    default: ok = 0;
                endcase
            endcase
            n.br = BranchIn; n.mr = MemReadIn; n.mw = MemWriteIn; n.mt = MemToRegIn;
            n.rw = RegWriteIn & ok;
            n.alu = r;
            n.z = (r == 0);
            n.sd = regBIn;
            n.wr = RegDstIn ? rdIn : rtIn;
            n.bt = PC_W'(PcCountIn + signExtendIn[PC_W-1:0]);
            if (mul) begin
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
        end
        exp_o = n;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        BranchIn = 0; MemReadIn = 0; MemWriteIn = 0; MemToRegIn = 0; RegWriteIn = 0;
        RegDstIn = 0; ALUSrcIn = 0; ALUOpIn = 2'b00;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        clear_ctl();
        ALUOpIn = 2'b10; RegDstIn = 1; RegWriteIn = 1;
        regAIn = a; regBIn = b; signExtendIn = {21'b0, sh, f};
        rdIn = 5'd3; rtIn = 5'd4;
    endtask

    task automatic test_reset();
        ALUOpIn = 2'b10; RegDstIn = 1; ALUSrcIn = 0; BranchIn = 1; MemReadIn = 1;
        MemWriteIn = 1; MemToRegIn = 1; RegWriteIn = 1; regAIn = 32'h1234; regBIn = 32'h55;
        signExtendIn = 32'h21; PcCountIn = 10'h12; rtIn = 5'd7; rdIn = 5'd8;
        reset = 1;
        tick();
        tick();
        n_chk++; if (got_o !== 85'b0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", got_o); end
        reset = 0;
        rtype(6'h10, 32'h1, 32'h2, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'h0) begin n_fail++; $display("FAIL reset_mfhi: got %h want 0", aluResult); end
        n_chk++; if (RegWriteOut !== 1'b1) begin n_fail++; $display("FAIL reset_mfhi_rw: got %b want 1", RegWriteOut); end
    endtask

    task automatic test_slt_sra();
        rtype(6'h2A, 32'hFFFFFFFF, 32'h1, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'h1) begin n_fail++; $display("FAIL slt: got %h want 1", aluResult); end
        rtype(6'h2B, 32'hFFFFFFFF, 32'h1, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'h0) begin n_fail++; $display("FAIL sltu: got %h want 0", aluResult); end
        n_chk++; if (zero !== 1'b1) begin n_fail++; $display("FAIL sltu_zero: got %b want 1", zero); end
        rtype(6'h03, 32'h0, 32'h80000000, 5'd4);
        tick();
        n_chk++; if (aluResult !== 32'hF8000000) begin n_fail++; $display("FAIL sra: got %h want f8000000", aluResult); end
    endtask

    task automatic test_branch();
        clear_ctl();
        ALUOpIn = 2'b01; BranchIn = 1; regAIn = 7; regBIn = 7;
        PcCountIn = 10'h3FE; signExtendIn = 32'd5;
        tick();
        n_chk++; if (zero !== 1'b1) begin n_fail++; $display("FAIL beq_zero: got %b want 1", zero); end
        n_chk++; if (BranchOut !== 1'b1) begin n_fail++; $display("FAIL beq_branch: got %b want 1", BranchOut); end
        n_chk++; if (branchTarget !== 10'h003) begin n_fail++; $display("FAIL beq_target: got %h want 003", branchTarget); end
    endtask

    task automatic test_mult();
        rtype(6'h18, 32'hFFFFFFFE, 32'd3, 5'd0);
        tick();
        n_chk++; if (RegWriteOut !== 1'b0) begin n_fail++; $display("FAIL mult_rw: got %b want 0", RegWriteOut); end
        n_chk++; if (aluResult !== 32'h0) begin n_fail++; $display("FAIL mult_alu: got %h want 0", aluResult); end
        rtype(6'h10, 32'h0, 32'h0, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", aluResult); end
        rtype(6'h12, 32'h0, 32'h0, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", aluResult); end
        rtype(6'h19, 32'hFFFFFFFE, 32'd3, 5'd0);
        tick();
        n_chk++; if (RegWriteOut !== 1'b0) begin n_fail++; $display("FAIL multu_rw: got %b want 0", RegWriteOut); end
        rtype(6'h10, 32'h0, 32'h0, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'h2) begin n_fail++; $display("FAIL multu_hi: got %h want 2", aluResult); end
        rtype(6'h12, 32'h0, 32'h0, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffa", aluResult); end
    endtask

    task automatic test_lw();
        clear_ctl();
        ALUSrcIn = 1; MemReadIn = 1; MemToRegIn = 1; RegWriteIn = 1;
        regAIn = 32'h100; regBIn = 32'h77; signExtendIn = 32'hFFFFFFFC; rtIn = 5'd9; rdIn = 5'd2;
        tick();
        n_chk++; if (aluResult !== 32'hFC) begin n_fail++; $display("FAIL lw_addr: got %h want fc", aluResult); end
        n_chk++; if (writeRegister !== 5'd9) begin n_fail++; $display("FAIL lw_dest: got %0d want 9", writeRegister); end
        n_chk++; if ({MemReadOut, MemToRegOut, RegWriteOut, MemWriteOut} !== 4'b1110)
            begin n_fail++; $display("FAIL lw_ctl: got %b want 1110", {MemReadOut, MemToRegOut, RegWriteOut, MemWriteOut}); end
    endtask

    task automatic test_stall_flush();
        rtype(6'h20, 32'd5, 32'd6, 5'd0);
        tick();
        rtype(6'h18, 32'd4, 32'd5, 5'd0);
        stall = 1;
        tick();
        tick();
        n_chk++; if (aluResult !== 32'd11 || RegWriteOut !== 1'b1)
            begin n_fail++; $display("FAIL stall_hold: got %h/%b want 0000000b/1", aluResult, RegWriteOut); end
        stall = 0;
        rtype(6'h10, 32'h0, 32'h0, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'h2) begin n_fail++; $display("FAIL stall_hi: got %h want 2", aluResult); end
        rtype(6'h12, 32'h0, 32'h0, 5'd0);
        tick();
        n_chk++; if (aluResult !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL stall_lo: got %h want fffffffa", aluResult); end
        clear_ctl();
        ALUSrcIn = 1; MemWriteIn = 1; regAIn = 32'h40; regBIn = 32'hDEAD; signExtendIn = 32'h8;
        flush = 1;
        tick();
        n_chk++; if (MemWriteOut !== 1'b0 || aluResult !== 32'h0)
            begin n_fail++; $display("FAIL flush_sw: got %b/%h want 0/0", MemWriteOut, aluResult); end
        flush = 0;
        rtype(6'h20, 32'd5, 32'd6, 5'd0);
        tick();
        flush = 1; stall = 1;
        tick();
        n_chk++; if (aluResult !== 32'h0 || RegWriteOut !== 1'b0 || writeRegister !== 5'd0)
            begin n_fail++; $display("FAIL flush_over_stall: got %h/%b/%0d want 0/0/0", aluResult, RegWriteOut, writeRegister); end
        flush = 0; stall = 0;
    endtask

    task automatic test_random();
        logic [5:0] functs [19];
        functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                   6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h3F, 6'h01};
        for (int i = 0; i < 300; i++) begin
            ALUOpIn = 2'($urandom_range(0, 3));
            RegDstIn = 1'($urandom); ALUSrcIn = 1'($urandom);
            BranchIn = 1'($urandom); MemReadIn = 1'($urandom); MemWriteIn = 1'($urandom);
            MemToRegIn = 1'($urandom); RegWriteIn = 1'($urandom);
            regAIn = $urandom; regBIn = $urandom; signExtendIn = $urandom;
            if (ALUOpIn == 2'b10) begin
                ALUSrcIn = 0;
                signExtendIn[5:0] = functs[$urandom_range(0, 18)];
            end
            PcCountIn = PC_W'($urandom); rtIn = 5'($urandom); rdIn = 5'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 11) == 0);
            stall = ($urandom_range(0, 7) == 0);
            tick();
            n_chk++; if (got_o !== exp_o) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", i, got_o, exp_o); end
        end
        reset = 0; flush = 0; stall = 0;
    endtask

    initial begin
        reset = 0; stall = 0; flush = 0;
        clear_ctl();
        regAIn = 0; regBIn = 0; signExtendIn = 0; PcCountIn = 0; rtIn = 0; rdIn = 0;
        exp_o = '0; m_hi = 0; m_lo = 0;
        test_reset();
        test_slt_sra();
        test_branch();
        test_mult();
        test_lw();
        test_stall_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage, directly downstream of the instruction-decode stage; consumes its registered ID/EX control, operand and register-index outputs.
- Performs ALU-control decode, ALU/shift/multiply operations, branch-target add and destination-register select.
- Holds the HI/LO architectural registers and the EX/MEM pipeline register feeding the memory stage.

Parameters:
- PC_W, 10, width of PC count / branch target (word-addressed instruction memory)

Ports:
- clk  in  1  pipeline clock; all state updates on falling edge
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold all outputs and HI/LO
- flush  in  1  insert bubble into EX/MEM
- ALUOpIn  in  2  00 add, 01 sub, 10 R-type by funct, 11 or (immediate)
- RegDstIn  in  1  1: dest = rd, 0: dest = rt
- ALUSrcIn  in  1  1: operand B = signExtendIn, 0: regBIn
- BranchIn, MemReadIn, MemWriteIn, MemToRegIn, RegWriteIn  in  1 each  ID/EX control
- regAIn, regBIn  in  32 each  register operands
- signExtendIn  in  32  immediate; [5:0] funct, [10:6] shamt
- PcCountIn  in  PC_W  PC+1 of this instruction
- rtIn, rdIn  in  5 each  register indices
- BranchOut, MemReadOut, MemWriteOut, MemToRegOut, RegWriteOut  out  1 each  EX/MEM control
- aluResult  out  32  ALU result
- zero  out  1  aluResult == 0
- storeData  out  32  regBIn passthrough for sw
- writeRegister  out  5  selected destination
- branchTarget  out  PC_W  PcCountIn + signExtendIn[PC_W-1:0], mod 2^PC_W

Behaviour:
- All outputs registered; one-cycle latency (falling edge). Priority: reset > flush > stall > normal.
- Reset: every output 0; HI = LO = 0.
- Flush: Branch/MemRead/MemWrite/MemToReg/RegWrite outputs 0; data outputs 0; HI/LO unchanged.
- Stall: all outputs and HI/LO hold.
- Operand B = ALUSrcIn ? signExtendIn : regBIn.
- ALUOp 00: A+B. 01: A−B. 11: A|B. No overflow traps; 32-bit wraparound.
- ALUOp 10, funct: 0x20/0x21 add; 0x22/0x23 sub; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor; 0x2A slt (signed); 0x2B sltu; 0x00 sll regB by shamt; 0x02 srl; 0x03 sra; 0x10 mfhi; 0x12 mflo.
- ALUOp 10, funct 0x18 mult (signed) / 0x19 multu: 64-bit product {HI,LO} written on the edge; aluResult = 0; RegWriteOut forced 0.
- Undefined funct: aluResult = 0; RegWriteOut forced 0.
- mfhi/mflo in the cycle immediately after a mult sees the new HI/LO (no hazard).
- zero computed from the registered aluResult value (registered together with it).
- writeRegister = RegDstIn ? rdIn : rtIn.
- branchTarget always computed, independent of BranchIn; wraps modulo 2^PC_W.
- reset asserted mid-stream clears everything on that edge; first valid result appears one edge after reset deasserts.

Test Plan:
- reset=1 for 2 cycles with nonzero inputs -> all outputs 0; a following mfhi returns 0.
- ALUOp=10, funct 0x2A, regA=0xFFFFFFFF, regB=1 -> aluResult=1. Same with 0x2B -> 0. funct 0x03, shamt 4, regB=0x80000000 -> 0xF8000000.
- ALUOp=01, regA=regB=7, Branch=1, PcCount=0x3FE, imm=5 -> zero=1, BranchOut=1, branchTarget=0x003.
- mult with regA=0xFFFFFFFE (−2), regB=3 -> RegWriteOut=0. Next instruction mfhi -> 0xFFFFFFFF; then mflo -> 0xFFFFFFFA. Repeat with multu -> HI=2, LO=0xFFFFFFFA.
- lw-like (ALUOp 00, ALUSrc=1, regA=0x100, imm=0xFFFFFFFC, RegDst=0, rt=9) -> aluResult=0xFC, writeRegister=9, MemRead/MemToReg/RegWrite=1.
- stall=1 during a mult -> outputs and HI/LO hold. Then flush=1 on an sw -> MemWriteOut=0, aluResult=0. Assert flush and stall together -> flush wins.
